// File: rtl/payload_sched_pkg.sv
// Shared types and helpers for the payload-match engine scheduler.
//   sched_state_t  : scheduler FSM states
//   DRAIN_CNT_W    : width of the post-stream drain counter (DRAIN_CYCLES <= 15)
//   MAX_ENGINES    : widest engine bank the priority helper supports
//   lowest_set_idx : index of the lowest set bit, 0 when no bit is set
package payload_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    REPORT
  } sched_state_t;

  localparam int DRAIN_CNT_W = 4;
  localparam int MAX_ENGINES = 256;

  // Lowest index wins; bits at or above 'width' are ignored.
  function automatic int lowest_set_idx(input logic [MAX_ENGINES-1:0] vec,
                                        input int                     width);
    int idx;
    bit found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_ENGINES; i++) begin
      if (!found && (i < width) && vec[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/payload_sched_prio_enc.sv
// Combinational priority encoder over the engine match vector.
// Ports:
//   match     in  NUM_ENGINES  engine end-state vector
//   first_idx out FIRST_W      lowest set index (0 if none set)
//   any_hit   out 1            OR of all match bits
module payload_sched_prio_enc
  import payload_sched_pkg::*;
#(
  parameter int NUM_ENGINES = 32,
  parameter int FIRST_W     = $clog2(NUM_ENGINES)
) (
  input  logic [NUM_ENGINES-1:0] match,
  output logic [FIRST_W-1:0]     first_idx,
  output logic                   any_hit
);

  logic [MAX_ENGINES-1:0] match_ext;

  always_comb begin
    match_ext                    = '0;
    match_ext[NUM_ENGINES-1:0]   = match;
    first_idx                    = FIRST_W'(lowest_set_idx(match_ext, NUM_ENGINES));
    any_hit                      = |match;
  end

endmodule

// File: rtl/payload_engine_sched.sv
// Scheduler for a bank of payload-match engines. Takes one packet at a time
// over a valid/ready byte stream, clears the engines with a one-cycle sod
// pulse, forwards each accepted byte with a one-cycle enable, waits for the
// engine pipeline to settle, then captures the match vector as a per-packet
// result on a valid/ready output.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready input byte stream
//   byte_out, en_out, sod_out    shared byte, enable and clear to the engines
//   match_in                     engine end-state vector
//   m_match/m_any/m_first/m_len  captured result fields
//   m_valid/m_ready              result handshake
//   stat_pkts, stat_hits         result counters, only with PAYLOAD_SCHED_STATS_EN
module payload_engine_sched
  import payload_sched_pkg::*;
#(
  parameter int NUM_ENGINES  = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int LEN_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic [7:0]                     byte_out,
  output logic                           en_out,
  output logic                           sod_out,
  input  logic [NUM_ENGINES-1:0]         match_in,
  output logic [NUM_ENGINES-1:0]         m_match,
  output logic                           m_any,
  output logic [$clog2(NUM_ENGINES)-1:0] m_first,
  output logic [LEN_W-1:0]               m_len,
  output logic                           m_valid,
  input  logic                           m_ready
`ifdef PAYLOAD_SCHED_STATS_EN
  ,
  output logic [31:0]                    stat_pkts,
  output logic [31:0]                    stat_hits
`endif
);

  localparam int FIRST_W = $clog2(NUM_ENGINES);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  sched_state_t           state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [LEN_W-1:0]       len_cnt;
  logic [FIRST_W-1:0]     enc_first;
  logic                   enc_any;
  logic                   accept;
  logic                   consume;
  logic                   load;

  assign accept  = s_valid && s_ready;
  assign consume = m_valid && m_ready;
  // The result register may be reloaded in the same cycle it is consumed.
  assign load    = (state == REPORT) && (!m_valid || m_ready);

  payload_sched_prio_enc #(
    .NUM_ENGINES (NUM_ENGINES),
    .FIRST_W     (FIRST_W)
  ) u_prio_enc (
    .match     (match_in),
    .first_idx (enc_first),
    .any_hit   (enc_any)
  );

  // Stage p0 -> p1: FSM, engine drive and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      len_cnt   <= '0;
      s_ready   <= 1'b0;
      byte_out  <= '0;
      en_out    <= 1'b0;
      sod_out   <= 1'b0;
      m_match   <= '0;
      m_any     <= 1'b0;
      m_first   <= '0;
      m_len     <= '0;
      m_valid   <= 1'b0;
    end else begin
      en_out  <= accept;
      sod_out <= 1'b0;
      if (accept) begin
        byte_out <= s_data;
      end

      case (state)
        IDLE: begin
          // The waiting byte is left on the bus until STREAM accepts it.
          if (s_valid) begin
            sod_out <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          len_cnt <= '0;
          s_ready <= 1'b1;
          state   <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            if (len_cnt != '1) begin
              len_cnt <= len_cnt + 1'b1;
            end
            if (s_last) begin
              s_ready   <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The cycle after the last accept carries the final en_out pulse;
          // DRAIN_CYCLES cycles from there the match vector is stable.
          if (drain_cnt == DRAIN_LAST) begin
            state <= REPORT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        REPORT: begin
          if (load) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        m_match <= match_in;
        m_any   <= enc_any;
        m_first <= enc_first;
        m_len   <= len_cnt;
        m_valid <= 1'b1;
      end else if (consume) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef PAYLOAD_SCHED_STATS_EN
  // Stage p1: result statistics, wrapping counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts <= '0;
      stat_hits <= '0;
    end else if (load) begin
      stat_pkts <= stat_pkts + 32'd1;
      if (enc_any) begin
        stat_hits <= stat_hits + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_payload_engine_sched.sv
// Testbench for payload_engine_sched: directed packets with literal
// expectations plus randomized packets, all checked every cycle against a
// packet-timeline reference model.
module tb_payload_engine_sched;

  localparam int NE    = 32;
  localparam int DRAIN = 2;
  localparam int LW    = 4;
  localparam int FW    = $clog2(NE);
  localparam int LMAX  = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [7:0]    byte_out;
  logic          en_out;
  logic          sod_out;
  logic [NE-1:0] match_in;
  logic [NE-1:0] m_match;
  logic          m_any;
  logic [FW-1:0] m_first;
  logic [LW-1:0] m_len;
  logic          m_valid;
  logic          m_ready;
`ifdef PAYLOAD_SCHED_STATS_EN
  logic [31:0]   stat_pkts;
  logic [31:0]   stat_hits;
`endif

  always #5 clk = ~clk;

  payload_engine_sched #(
    .NUM_ENGINES  (NE),
    .DRAIN_CYCLES (DRAIN),
    .LEN_W        (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .byte_out (byte_out),
    .en_out   (en_out),
    .sod_out  (sod_out),
    .match_in (match_in),
    .m_match  (m_match),
    .m_any    (m_any),
    .m_first  (m_first),
    .m_len    (m_len),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
`ifdef PAYLOAD_SCHED_STATS_EN
    ,
    .stat_pkts (stat_pkts),
    .stat_hits (stat_hits)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: absolute cycle numbers of the packet timeline.
  bit            pkt_open;
  int            sod_at;
  int            rdy_from;
  int            report_at;
  int            idle_at;
  int            byte_cnt;
  bit            hs_prev;
  logic [7:0]    byte_m;
  bit            mv;
  logic [NE-1:0] mm;
  logic [LW-1:0] ml;
  int unsigned   pkts_m;
  int unsigned   hits_m;

  // Observations for the directed checks.
  int         sod_total;
  int         en_total;
  bit         smp_acc;
  bit         smp_sod;
  int         sod_n;
  bit         sod_before;
  int         last_hs;
  bit         rand_ready;
  logic [7:0] pkt_bytes [0:31];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int low_idx(input logic [NE-1:0] v);
    for (int i = 0; i < NE; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    pkt_open  = 1'b0;
    report_at = -1;
    idle_at   = cyc + 1;
    byte_cnt  = 0;
    hs_prev   = 1'b0;
    byte_m    = '0;
    mv        = 1'b0;
    mm        = '0;
    ml        = '0;
    pkts_m    = 0;
    hits_m    = 0;
  endtask

  // Called at the falling edge: compare this cycle's outputs, then advance.
  task automatic model_step();
    bit e_sod;
    bit e_rdy;
    bit hs;
    bit load;
    e_sod = pkt_open && (cyc == sod_at);
    e_rdy = pkt_open && (cyc >= rdy_from) && (report_at < 0);
    chk("sod_out",  64'(sod_out),  64'(e_sod));
    chk("s_ready",  64'(s_ready),  64'(e_rdy));
    chk("en_out",   64'(en_out),   64'(hs_prev));
    chk("byte_out", 64'(byte_out), 64'(byte_m));
    chk("m_valid",  64'(m_valid),  64'(mv));
    chk("m_match",  64'(m_match),  64'(mm));
    chk("m_any",    64'(m_any),    64'(mm != '0));
    chk("m_first",  64'(m_first),  64'(low_idx(mm)));
    chk("m_len",    64'(m_len),    64'(ml));
`ifdef PAYLOAD_SCHED_STATS_EN
    chk("stat_pkts", 64'(stat_pkts), 64'(pkts_m));
    chk("stat_hits", 64'(stat_hits), 64'(hits_m));
`endif
    smp_acc = s_valid && s_ready;
    smp_sod = sod_out;
    if (sod_out) sod_total++;
    if (en_out) en_total++;

    if (rst) begin
      model_reset();
    end else begin
      hs      = e_rdy && s_valid;
      hs_prev = hs;
      if (hs) begin
        byte_m = s_data;
        byte_cnt++;
        if (s_last) report_at = cyc + DRAIN + 1;
      end
      load = pkt_open && (report_at >= 0) && (cyc >= report_at) && (!mv || m_ready);
      if (load) begin
        mv = 1'b1;
        mm = match_in;
        ml = (byte_cnt > LMAX) ? LW'(LMAX) : LW'(byte_cnt);
        pkts_m++;
        if (match_in != '0) hits_m++;
        pkt_open = 1'b0;
        idle_at  = cyc + 1;
      end else if (mv && m_ready) begin
        mv = 1'b0;
      end
      if (!pkt_open && (cyc >= idle_at) && s_valid) begin
        pkt_open  = 1'b1;
        sod_at    = cyc + 1;
        rdy_from  = cyc + 2;
        report_at = -1;
        byte_cnt  = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Sends pkt_bytes[0..n-1]; stops early after stop_after handshakes when
  // stop_after >= 0. For a complete packet, match_in is set one cycle after
  // the last en_out pulse and held until the next packet's sod.
  task automatic send_pkt(input int n, input logic [NE-1:0] mval, input bit gaps,
                          input int stop_after);
    int i;
    int guard;
    i          = 0;
    guard      = 0;
    sod_n      = 0;
    sod_before = 1'b0;
    while (i < n && i != stop_after && guard < 3000) begin
      s_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_data  = pkt_bytes[i];
      s_last  = (i == n - 1);
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (smp_sod) begin
        sod_n++;
        match_in = '0;
      end
      if (smp_acc) begin
        if (i == 0) sod_before = (sod_n == 1);
        last_hs = cyc - 1;
        i++;
      end
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (guard >= 3000) chk("send_timeout", 64'(i), 64'(n));
    if (i == n) begin
      tick();
      match_in = mval;
    end
  endtask

  task automatic wait_result(input int maxc);
    int k;
    k = 0;
    while (!m_valid && k < maxc) begin
      tick();
      k++;
    end
    chk("result_arrives", 64'(m_valid), 64'd1);
  endtask

  int               en0;
  int               n;
  logic [NE-1:0]    mval;

  initial begin
    rst        = 1'b1;
    s_data     = '0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    match_in   = '0;
    m_ready    = 1'b1;
    rand_ready = 1'b0;
    sod_total  = 0;
    en_total   = 0;
    last_hs    = 0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_en_out",  64'(en_out),  64'd0);
    rst = 1'b0;
    tick();

    // "mus\r", bit 5 matches.
    pkt_bytes[0] = 8'h6d; pkt_bytes[1] = 8'h75; pkt_bytes[2] = 8'h73; pkt_bytes[3] = 8'h0d;
    en0 = en_total;
    send_pkt(4, 32'h20, 1'b0, -1);
    wait_result(20);
    chk("t1_latency",   64'(cyc - last_hs), 64'(DRAIN + 2));
    chk("t1_m_match",   64'(m_match), 64'h20);
    chk("t1_m_any",     64'(m_any),   64'd1);
    chk("t1_m_first",   64'(m_first), 64'd5);
    chk("t1_m_len",     64'(m_len),   64'd4);
    chk("t1_en_pulses", 64'(en_total - en0), 64'd4);
    chk("t1_sod_count", 64'(sod_n), 64'd1);
    chk("t1_sod_first", 64'(sod_before), 64'd1);
    repeat (2) tick();

    // Gapped 3-byte packet, no match.
    pkt_bytes[0] = 8'h41; pkt_bytes[1] = 8'h42; pkt_bytes[2] = 8'h43;
    en0 = en_total;
    send_pkt(3, '0, 1'b1, -1);
    wait_result(20);
    chk("t2_m_len",     64'(m_len),   64'd3);
    chk("t2_m_any",     64'(m_any),   64'd0);
    chk("t2_m_first",   64'(m_first), 64'd0);
    chk("t2_en_pulses", 64'(en_total - en0), 64'd3);
    repeat (2) tick();

    // Back-to-back packets with the consumer stalled.
    m_ready = 1'b0;
    pkt_bytes[0] = 8'h10; pkt_bytes[1] = 8'h11;
    send_pkt(2, 32'h100, 1'b0, -1);
    wait_result(20);
    chk("t3a_m_first", 64'(m_first), 64'd8);
    pkt_bytes[0] = 8'h20; pkt_bytes[1] = 8'h21; pkt_bytes[2] = 8'h22;
    send_pkt(3, 32'h8000_0001, 1'b0, -1);
    repeat (10) tick();
    chk("t3_hold_valid", 64'(m_valid), 64'd1);
    chk("t3_hold_match", 64'(m_match), 64'h100);
    chk("t3_hold_len",   64'(m_len),   64'd2);
    chk("t3_wait_ready", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t3b_valid", 64'(m_valid), 64'd1);
    chk("t3b_match", 64'(m_match), 64'h8000_0001);
    chk("t3b_first", 64'(m_first), 64'd0);
    chk("t3b_len",   64'(m_len),   64'd3);
    m_ready = 1'b1;
    tick();
    chk("t3_drained", 64'(m_valid), 64'd0);
    repeat (2) tick();

    // Reset mid-stream with a result still pending.
    m_ready = 1'b0;
    pkt_bytes[0] = 8'h55;
    send_pkt(1, 32'h1, 1'b0, -1);
    wait_result(20);
    pkt_bytes[0] = 8'h31; pkt_bytes[1] = 8'h32; pkt_bytes[2] = 8'h33;
    pkt_bytes[3] = 8'h34; pkt_bytes[4] = 8'h35;
    send_pkt(5, '0, 1'b0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_m_valid",  64'(m_valid),  64'd0);
    chk("t4_s_ready",  64'(s_ready),  64'd0);
    chk("t4_en_out",   64'(en_out),   64'd0);
    chk("t4_byte_out", 64'(byte_out), 64'd0);
    chk("t4_m_match",  64'(m_match),  64'd0);
    chk("t4_m_len",    64'(m_len),    64'd0);
    m_ready = 1'b1;
    repeat (3) tick();
    pkt_bytes[0] = 8'h61; pkt_bytes[1] = 8'h62; pkt_bytes[2] = 8'h63;
    send_pkt(3, 32'h4, 1'b0, -1);
    wait_result(20);
    chk("t4_new_len",   64'(m_len),   64'd3);
    chk("t4_new_first", 64'(m_first), 64'd2);
    chk("t4_sod_count", 64'(sod_n), 64'd1);
    chk("t4_sod_first", 64'(sod_before), 64'd1);
    repeat (2) tick();

    // 20-byte packet saturates the 4-bit length.
    for (int i = 0; i < 20; i++) pkt_bytes[i] = 8'($urandom);
    send_pkt(20, 32'h8000_0000, 1'b0, -1);
    wait_result(20);
    chk("t5_m_len",   64'(m_len),   64'd15);
    chk("t5_m_first", 64'(m_first), 64'd31);
    repeat (2) tick();

`ifdef PAYLOAD_SCHED_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stats_reset", 64'(stat_pkts), 64'd0);
    pkt_bytes[0] = 8'h01;
    send_pkt(1, 32'h1, 1'b0, -1);
    wait_result(20);
    tick();
    send_pkt(1, '0, 1'b0, -1);
    wait_result(20);
    tick();
    send_pkt(1, 32'h10, 1'b0, -1);
    wait_result(20);
    chk("stat_pkts_3", 64'(stat_pkts), 64'd3);
    chk("stat_hits_2", 64'(stat_hits), 64'd2);
    repeat (2) tick();
`endif

    // Randomized packets, gaps and consumer backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) pkt_bytes[i] = 8'($urandom);
      mval = ($urandom_range(0, 1) == 1) ? NE'($urandom) : '0;
      send_pkt(n, mval, 1'b1, -1);
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    repeat (30) tick();
    chk("final_idle", 64'(m_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
